// File: rtl/keyb_pkg.sv
// Shared definitions for the keypad scanner: default geometry, event-type encoding and
// key-index helpers. KEYB_RELEASE_EVT_EN adds the release flag bit to every key code.
package keyb_pkg;

    localparam int unsigned DEF_NUM_COLS       = 4;
    localparam int unsigned DEF_NUM_ROWS       = 4;
    localparam int unsigned DEF_SCAN_DIV       = 4;
    localparam int unsigned DEF_DEBOUNCE_SCANS = 2;
    localparam int unsigned DEF_FIFO_DEPTH     = 4;

    typedef enum logic {
        EVT_PRESS   = 1'b0,
        EVT_RELEASE = 1'b1
    } evt_type_e;

`ifdef KEYB_RELEASE_EVT_EN
    localparam int unsigned REL_W = 1;
`else
    localparam int unsigned REL_W = 0;
`endif

    // Index field width, never narrower than one bit.
    function automatic int unsigned field_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    function automatic int unsigned key_row(input int unsigned idx, input int unsigned ncols);
        return idx / ncols;
    endfunction

    function automatic int unsigned key_col(input int unsigned idx, input int unsigned ncols);
        return idx % ncols;
    endfunction

endpackage

// File: rtl/keyb_event_fifo.sv
// Synchronous first-word-fall-through event queue; head is valid whenever empty is low.
// Push while full is accepted only when a pop happens in the same cycle.
module keyb_event_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/keyb_scan_fifo.sv
// Matrix keypad scanner: column strobing, full-matrix debounce and press/release event queue.
// Define KEYB_RELEASE_EVT_EN to also queue release events (key_code gains a top release bit).
module keyb_scan_fifo
    import keyb_pkg::*;
#(
    parameter  int unsigned NUM_COLS       = DEF_NUM_COLS,
    parameter  int unsigned NUM_ROWS       = DEF_NUM_ROWS,
    parameter  int unsigned SCAN_DIV       = DEF_SCAN_DIV,
    parameter  int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter  int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
    localparam int unsigned CW             = field_w(NUM_COLS),
    localparam int unsigned RW             = field_w(NUM_ROWS),
    localparam int unsigned KW             = RW + CW + REL_W
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_COLS-1:0] cols,
    input  logic [NUM_ROWS-1:0] rows,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [KW-1:0]       key_code,
    output logic                any_pressed,
    output logic                scan_done,
    output logic                overflow
);

    localparam int unsigned NK  = NUM_COLS * NUM_ROWS;
    localparam int unsigned DW  = field_w(SCAN_DIV);
    localparam int unsigned DBW = $clog2(DEBOUNCE_SCANS + 1);

    logic [DW-1:0]  dwell;
    logic [CW-1:0]  col_idx;
    logic [NK-1:0]  snapshot;
    logic [NK-1:0]  candidate;
    logic [NK-1:0]  stable;
    logic [NK-1:0]  pending;
    logic [DBW-1:0] db_cnt;

    logic           dwell_end;
    logic           last_col;
    logic [NK-1:0]  cand_next;
    logic [DBW-1:0] cnt_next;
    logic           commit;

    logic [NK-1:0]  low_bit;
    logic [RW-1:0]  ev_row;
    logic [CW-1:0]  ev_col;
    logic           ev_press;
    logic [KW-1:0]  ev_code;
    logic           ev_push;
    logic           fifo_full;
    logic           fifo_empty;

    assign dwell_end = (dwell == DW'(SCAN_DIV - 1));
    assign last_col  = (col_idx == CW'(NUM_COLS - 1));

    // Debounce decision is evaluated every cycle but only acted on while scan_done is high.
    always_comb begin
        cand_next = candidate;
        cnt_next  = db_cnt;
        if (snapshot != candidate) begin
            cand_next = snapshot;
            cnt_next  = DBW'(1);
        end else if (db_cnt != DBW'(DEBOUNCE_SCANS)) begin
            cnt_next = db_cnt + DBW'(1);
        end
        commit = scan_done && (cnt_next == DBW'(DEBOUNCE_SCANS))
                 && (cand_next != stable) && (pending == '0);
    end

    assign low_bit = pending & (~pending + NK'(1));

    // Descending walk so the lowest set pending bit wins.
    always_comb begin
        ev_row   = '0;
        ev_col   = '0;
        ev_press = 1'b0;
        for (int unsigned i = NK; i > 0; i--) begin
            if (pending[i-1]) begin
                ev_row   = RW'(key_row(i - 1, NUM_COLS));
                ev_col   = CW'(key_col(i - 1, NUM_COLS));
                ev_press = stable[i-1];
            end
        end
    end

`ifdef KEYB_RELEASE_EVT_EN
    evt_type_e ev_type;
    assign ev_type = ev_press ? EVT_PRESS : EVT_RELEASE;
    assign ev_code = {ev_type, ev_row, ev_col};
    assign ev_push = (pending != '0);
`else
    assign ev_code = {ev_row, ev_col};
    assign ev_push = (pending != '0) && ev_press;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cols        <= NUM_COLS'(1);
            dwell       <= '0;
            col_idx     <= '0;
            snapshot    <= '0;
            candidate   <= '0;
            stable      <= '0;
            pending     <= '0;
            db_cnt      <= '0;
            any_pressed <= 1'b0;
            scan_done   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            scan_done <= dwell_end && last_col;

            if (dwell_end) begin
                dwell   <= '0;
                cols    <= {cols[NUM_COLS-2:0], cols[NUM_COLS-1]};
                col_idx <= last_col ? '0 : col_idx + CW'(1);
                for (int unsigned c = 0; c < NUM_COLS; c++) begin
                    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                        if (col_idx == CW'(c)) begin
                            snapshot[r*NUM_COLS + c] <= rows[r];
                        end
                    end
                end
            end else begin
                dwell <= dwell + DW'(1);
            end

            if (scan_done) begin
                candidate <= cand_next;
                db_cnt    <= cnt_next;
            end

            if (pending != '0) begin
                pending <= pending & ~low_bit;
            end else if (commit) begin
                pending     <= cand_next ^ stable;
                stable      <= cand_next;
                any_pressed <= |cand_next;
            end

            if (ev_push && fifo_full && !key_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    keyb_event_fifo #(
        .WIDTH (KW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (ev_push),
        .push_data (ev_code),
        .pop       (key_ready),
        .head      (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_valid = !fifo_empty;

endmodule

// File: tb/tb_keyb_scan_fifo.sv
// Self-checking bench for keyb_scan_fifo: directed scenarios plus randomized key matrices,
// compared each cycle against a queue-based behavioural model of the scanner.
module tb_keyb_scan_fifo;

    localparam int NC  = 4;
    localparam int NR  = 4;
    localparam int SD  = 4;
    localparam int DEB = 2;
    localparam int FD  = 4;
    localparam int NK  = NC * NR;
    localparam int CW  = 2;
    localparam int RW  = 2;
`ifdef KEYB_RELEASE_EVT_EN
    localparam int KW     = 5;
    localparam bit REL_EN = 1'b1;
`else
    localparam int KW     = 4;
    localparam bit REL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] cols;
    logic [NR-1:0] rows;
    logic          key_valid;
    logic          key_ready;
    logic [KW-1:0] key_code;
    logic          any_pressed;
    logic          scan_done;
    logic          overflow;

    always #5 clk = ~clk;

    keyb_scan_fifo #(
        .NUM_COLS       (NC),
        .NUM_ROWS       (NR),
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cols        (cols),
        .rows        (rows),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_code    (key_code),
        .any_pressed (any_pressed),
        .scan_done   (scan_done),
        .overflow    (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Behavioural model: scan position, debounce history, pending event list, queue contents.
    int          m_t;
    bit          m_sd;
    bit [NK-1:0] m_snap;
    bit [NK-1:0] m_cand;
    bit [NK-1:0] m_stable;
    int          m_cnt;
    bit          m_ovf;
    int          pend_q[$];
    int          fifo_q[$];
    int          dut_pops[$];

    function automatic int key_code_of(input int idx, input bit rel);
        return (int'(rel) << (RW + CW)) | ((idx / NC) << CW) | (idx % NC);
    endfunction

    task automatic model_edge(input bit rst, input bit rdy, input logic [NR-1:0] rw);
        bit          pend_empty;
        bit          pop;
        bit          commit;
        bit [NK-1:0] diff;
        int          e;
        if (rst) begin
            m_t = 0; m_sd = 0; m_snap = '0; m_cand = '0; m_stable = '0;
            m_cnt = 0; m_ovf = 0;
            pend_q.delete();
            fifo_q.delete();
            return;
        end
        pend_empty = (pend_q.size() == 0);
        pop        = (fifo_q.size() > 0) && rdy;
        commit     = 0;
        diff       = '0;
        if (m_sd) begin
            if (m_snap != m_cand) begin
                m_cand = m_snap;
                m_cnt  = 1;
            end else if (m_cnt < DEB) begin
                m_cnt++;
            end
            if (m_cnt == DEB && m_cand != m_stable && pend_empty) begin
                diff     = m_cand ^ m_stable;
                m_stable = m_cand;
                commit   = 1;
            end
        end
        if (pop) void'(fifo_q.pop_front());
        if (!pend_empty) begin
            e = pend_q.pop_front();
            if ((e % 2 == 1) || REL_EN) begin
                if (fifo_q.size() < FD) fifo_q.push_back(key_code_of(e / 2, e % 2 == 0));
                else m_ovf = 1;
            end
        end
        if (commit) begin
            for (int i = 0; i < NK; i++) if (diff[i]) pend_q.push_back(i * 2 + int'(m_stable[i]));
        end
        if (m_t % SD == SD - 1) begin
            for (int r = 0; r < NR; r++) m_snap[r*NC + m_t/SD] = rw[r];
        end
        m_sd = (m_t == NC * SD - 1);
        m_t  = (m_t + 1) % (NC * SD);
    endtask

    // One clock: check outputs at the negedge, drive inputs, advance the model at the posedge.
    task automatic cycle(input bit rst, input bit [NK-1:0] keys, input int rdy_mode);
        bit rdy;
        check("cols", 32'(cols), 32'(1 << (m_t / SD)));
        check("scan_done", 32'(scan_done), 32'(m_sd));
        check("key_valid", 32'(key_valid), 32'(fifo_q.size() > 0));
        if (fifo_q.size() > 0) check("key_code", 32'(key_code), 32'(fifo_q[0]));
        check("any_pressed", 32'(any_pressed), 32'(|m_stable));
        check("overflow", 32'(overflow), 32'(m_ovf));
        rdy = (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(rdy_mode);
        if (key_valid && rdy && !rst) dut_pops.push_back(int'(key_code));
        for (int r = 0; r < NR; r++) rows[r] = keys[r*NC + m_t/SD];
        key_ready = rdy;
        reset     = rst;
        @(posedge clk);
        model_edge(rst, rdy, rows);
        @(negedge clk);
    endtask

    task automatic run_scans(input bit [NK-1:0] keys, input int n, input int rdy_mode);
        int guard;
        for (int s = 0; s < n; s++) begin
            guard = 0;
            do begin
                cycle(1'b0, keys, rdy_mode);
                guard++;
            end while (m_t != 0 && guard < NC * SD);
        end
    endtask

    task automatic check_pops(input string tag, input int exp[$]);
        check({tag, "_count"}, 32'(dut_pops.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_pops.size(); i++)
            check(tag, 32'(dut_pops[i]), 32'(exp[i]));
    endtask

    initial begin
        int          exp[$];
        bit [NK-1:0] acc;
        bit [NK-1:0] rk;
        int          press_idx[5] = '{1, 4, 7, 10, 13};

        reset = 1'b1; rows = '0; key_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_edge(1'b1, 1'b0, '0);
        @(negedge clk);
        check("reset_key_code", 32'(key_code), 32'h0);
        check("reset_cols", 32'(cols), 32'h1);
        check("reset_valid", 32'(key_valid), 32'h0);

        // Idle scanning: column rotation and scan_done cadence.
        run_scans('0, 2, 1);
        exp.delete();
        check_pops("idle", exp);

        // Single key r1c2 pressed then released.
        dut_pops.delete();
        run_scans(NK'(1) << 6, 3, 1);
        run_scans('0, 3, 1);
        exp.delete(); exp.push_back(32'h06);
        if (REL_EN) exp.push_back(32'h16);
        check_pops("single", exp);

        // One-scan glitch must not produce an event.
        dut_pops.delete();
        run_scans(NK'(1) << 5, 1, 1);
        run_scans('0, 3, 1);
        exp.delete();
        check_pops("glitch", exp);

        // Two simultaneous keys held with the consumer stalled.
        dut_pops.delete();
        run_scans((NK'(1) << 0) | (NK'(1) << 15), 3, 0);
        check("twokey_head", 32'(key_code), 32'h00);
        check("twokey_valid", 32'(key_valid), 32'h1);
        run_scans('0, 3, 0);
        check("twokey_head_hold", 32'(key_code), 32'h00);
        check("twokey_ovf", 32'(overflow), 32'h0);
        run_scans('0, 2, 1);
        exp.delete(); exp.push_back(32'h00); exp.push_back(32'h0F);
        if (REL_EN) begin exp.push_back(32'h10); exp.push_back(32'h1F); end
        check_pops("twokey", exp);

        // Five separate presses into a stalled four-entry queue.
        dut_pops.delete();
        acc = '0;
        foreach (press_idx[k]) begin
            acc |= NK'(1) << press_idx[k];
            run_scans(acc, 2, 0);
        end
        run_scans(acc, 1, 0);
        check("ovf_set", 32'(overflow), 32'h1);
        run_scans(acc, 2, 1);
        exp.delete();
        exp.push_back(32'h01); exp.push_back(32'h04); exp.push_back(32'h07); exp.push_back(32'h0A);
        check_pops("ovf_drain", exp);
        run_scans('0, 3, 1);

        // Reset while two events are queued.
        run_scans((NK'(1) << 2) | (NK'(1) << 3), 3, 0);
        check("pre_reset_valid", 32'(key_valid), 32'h1);
        for (int i = 0; i < 5; i++) cycle(1'b0, (NK'(1) << 2) | (NK'(1) << 3), 0);
        cycle(1'b1, '0, 0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_cols", 32'(cols), 32'h1);
        dut_pops.delete();
        run_scans('0, 2, 1);
        exp.delete();
        check_pops("post_reset", exp);

        // Press and release of r2c1.
        dut_pops.delete();
        run_scans(NK'(1) << 9, 3, 1);
        run_scans('0, 3, 1);
        exp.delete(); exp.push_back(32'h09);
        if (REL_EN) exp.push_back(32'h19);
        check_pops("r2c1", exp);

        // Randomized sparse matrices with a randomly stalling consumer.
        rk = '0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 1) == 0) rk = NK'($urandom & $urandom & $urandom);
            run_scans(rk, 1, 2);
        end
        run_scans('0, 4, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
